// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the execute-stage M-extension unit: op-class code, funct7/funct3
// opcodes and the sequencer state encoding.
package muldiv_unit_pkg;

  localparam logic [2:0] MDU_ALU_OP_CLASS = 3'b101;
  localparam logic [6:0] FUNCT7_M         = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDiv  = 2'b10,
    StDone = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage request/response bundle between the control path and the M unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALU_OP_W = 3
);
  logic                start_i;
  logic [ALU_OP_W-1:0] ALU_Op_i;
  logic [6:0]          funct7_i;
  logic [2:0]          funct3_i;
  logic [XLEN-1:0]     rs1_data_i;
  logic [XLEN-1:0]     rs2_data_i;
  logic                flush_i;
  logic                mdu_sel_o;
  logic                busy_o;
  logic                stall_o;
  logic                done_o;
  logic [XLEN-1:0]     result_o;

  modport master (
    output start_i, ALU_Op_i, funct7_i, funct3_i, rs1_data_i, rs2_data_i, flush_i,
    input  mdu_sel_o, busy_o, stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, ALU_Op_i, funct7_i, funct3_i, rs1_data_i, rs2_data_i, flush_i,
    output mdu_sel_o, busy_o, stall_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_seq_core.sv
// Iteration engine shared by the shift-add multiplier and the restoring divider;
// operands arrive as unsigned magnitudes and acc_next exposes the step about to be taken.
module muldiv_seq_core #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [CNT_W-1:0]  cnt,
  output logic [2*XLEN-1:0] acc_next
);

  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;

  // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, b_q};
    if (is_div) begin
      acc_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      b_q   <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(XLEN);
      acc_q <= {{XLEN{1'b0}}, a_mag};
      b_q   <= b_mag;
    end else if (step) begin
      cnt_q <= cnt_q - CNT_W'(1);
      acc_q <= acc_next;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: decode, sign handling, divide special cases and the sequencing
// FSM around the shared iteration core.
module muldiv_unit import muldiv_unit_pkg::*; #(
  parameter int unsigned         XLEN       = 32,
  parameter int unsigned         ALU_OP_W   = 3,
  parameter logic [ALU_OP_W-1:0] MDU_ALU_OP = ALU_OP_W'(MDU_ALU_OP_CLASS)
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned     CNT_W  = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  logic [2:0]        op_q;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              accept, last, busy;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic              div_by_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc_next, prod_fix;
  logic [XLEN-1:0]   div_pick, div_fix;

  assign bus.mdu_sel_o = (bus.ALU_Op_i == MDU_ALU_OP) && (bus.funct7_i == FUNCT7_M);
  assign bus.stall_o   = bus.start_i & bus.mdu_sel_o & ~bus.done_o;
  assign busy          = (state_q == StMul) || (state_q == StDiv);
  assign bus.busy_o    = busy;
  assign bus.done_o    = (state_q == StDone);
  assign bus.result_o  = result_q;
  assign accept        = (state_q == StIdle) && bus.start_i && bus.mdu_sel_o && !bus.flush_i;
  assign last          = (cnt == CNT_W'(1));

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.funct3_i)
      F3_MULH, F3_DIV, F3_REM:           begin a_signed = 1'b1; b_signed = 1'b1; end
      F3_MULHSU:                         a_signed = 1'b1;
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: ;
      default: ;
    endcase
    a_neg       = a_signed & bus.rs1_data_i[XLEN-1];
    b_neg       = b_signed & bus.rs2_data_i[XLEN-1];
    a_mag       = a_neg ? -bus.rs1_data_i : bus.rs1_data_i;
    b_mag       = b_neg ? -bus.rs2_data_i : bus.rs2_data_i;
    // Remainder follows the dividend; everything else follows the product of signs.
    neg_d       = (bus.funct3_i[2] & bus.funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
    div_by_zero = bus.funct3_i[2] && (bus.rs2_data_i == '0);
    div_ovf     = bus.funct3_i[2] && !bus.funct3_i[0] && (bus.rs1_data_i == MinNeg) &&
                  (bus.rs2_data_i == '1);
  end

  assign prod_fix = neg_q ? -acc_next : acc_next;
  assign div_pick = op_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
  assign div_fix  = neg_q ? -div_pick : div_pick;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    if (bus.flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (!bus.funct3_i[2]) begin
              state_d = StMul;
            end else if (div_by_zero) begin
              state_d  = StDone;
              result_d = bus.funct3_i[1] ? bus.rs1_data_i : '1;
            end else if (div_ovf) begin
              state_d  = StDone;
              result_d = bus.funct3_i[1] ? '0 : bus.rs1_data_i;
            end else begin
              state_d = StDiv;
            end
          end
        end
        StMul: begin
          if (last) begin
            state_d  = StDone;
            result_d = (op_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          end
        end
        StDiv: begin
          if (last) begin
            state_d  = StDone;
            result_d = div_fix;
          end
        end
        StDone: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        op_q  <= bus.funct3_i;
        neg_q <= neg_d;
      end
    end
  end

  muldiv_seq_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (busy),
    .is_div   (state_q == StDiv),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .cnt      (cnt),
    .acc_next (acc_next)
  );

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, parametrised in datapath width.
- Sits beside the ALU in the execute stage and is selected when the ALU operation class is the new M-type code.
- Decodes funct7/funct3 into eight M operations and runs a shift-add multiplier or restoring divider over XLEN cycles.
- Raises a stall toward the PC/register-write path until the result is ready.

Parameters:
- XLEN, 32, operand and result width (even, >= 8).
- ALU_OP_W, 3, width of the ALU operation class input.
- MDU_ALU_OP, 3'b101, ALU operation class value that marks an M-type instruction.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  instruction valid in execute this cycle.
- ALU_Op_i  in  ALU_OP_W  operation class from the main control unit.
- funct7_i  in  7  instruction funct7 field.
- funct3_i  in  3  instruction funct3 field.
- rs1_data_i  in  XLEN  operand A.
- rs2_data_i  in  XLEN  operand B.
- flush_i  in  1  abort the in-flight operation.
- mdu_sel_o  out  1  combinational; 1 when ALU_Op_i==MDU_ALU_OP and funct7_i==7'b0000001 (writeback mux select).
- busy_o  out  1  FSM not IDLE and not DONE.
- stall_o  out  1  combinational: start_i & mdu_sel_o & ~done_o.
- done_o  out  1  one-cycle pulse, result valid.
- result_o  out  XLEN  result, held until the next accepted start.

Behaviour:
- Reset (async, any state): FSM=IDLE; counter, accumulators and result_o cleared; busy_o=0, done_o=0.
- funct3 decode:
  - 000 MUL (low XLEN bits).
  - 001 MULH (s×s, high).
  - 010 MULHSU (s×u, high).
  - 011 MULHU (u×u, high).
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_i & mdu_sel_o latches operands and op, converts signed operands to magnitudes, records the sign fixups, and loads counter=XLEN.
  - funct3[2]=0 goes to MUL.
  - funct3[2]=1 goes to DIV, except the special cases, which go straight to DONE.
- Special cases, one-cycle fast path (done_o the cycle after the start edge):
  - Divisor==0: quotient=all ones, remainder=dividend.
  - Signed overflow (DIV/REM with dividend=2^(XLEN-1), divisor=-1): quotient=dividend, remainder=0.
- MUL:
  - Radix-2 shift-add into a 2*XLEN product, one bit per cycle, counter decrements.
  - At counter==1, apply sign negation if needed and go to DONE.
- DIV:
  - Restoring division, one quotient bit per cycle.
  - Quotient sign = sign(A) XOR sign(B); remainder takes the sign of the dividend.
  - At counter==1, go to DONE.
- Latency: normal ops assert done_o exactly XLEN+1 cycles after the start edge, independent of operand values.
- DONE:
  - done_o=1 and result_o updated for one cycle, then back to IDLE.
  - The next start is accepted no earlier than the cycle after DONE.
- start_i while MUL/DIV/DONE: ignored; operands are not re-latched.
- flush_i: any state goes to IDLE next edge, with no done_o pulse and result_o unchanged. flush_i has priority over start_i in the same cycle.
- stall_o stays high while the same instruction is held; the control path must keep start_i and operands stable until done_o.
- Non-M instructions: mdu_sel_o=0, no state change.

Decomposition:
- Shared package (alongside the existing ALU op-class localparams):
  - MDU_ALU_OP value.
  - M funct7 constant 7'b0000001.
  - The eight funct3 opcode constants.
  - FSM state encoding (2-bit).
- Natural sub-module: muldiv_seq_core.
  - Holds the counter, shift registers, and add/subtract step for both algorithms.
  - muldiv_unit keeps decode, sign handling, special cases and FSM.

Test Plan:
- MUL 7 × 0xFFFFFFFD -> result_o=0xFFFFFFEB; done_o exactly 33 cycles after start edge; stall_o high until then.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, both with done_o one cycle after start; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Start MUL, assert flush_i at cycle 10 -> IDLE next edge, no done_o, result_o keeps previous value; a new DIVU 9/3 then completes with result 3.
- Assert reset mid-DIV (cycle 5, asynchronously between edges) -> busy_o/done_o/result_o=0 immediately; start_i during busy is ignored with operands not re-latched.
